// File: rtl/rca_nb.sv
// rtl/rca_nb.sv - n-bit ripple-carry adder
// Chain of full adders; the carry ripples from bit 0 to bit n-1.
module rca_nb #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         co
);

  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[n];

endmodule

// File: rtl/mult_sa_nb.sv
// rtl/mult_sa_nb.sv - unsigned n x n shift-and-add multiplier
// Retires one multiplier bit per clock through a single rca_nb.
module mult_sa_nb #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] prod
);

  localparam int cw = $clog2(n) + 1;
  localparam logic [cw-1:0] last = cw'(n - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_run,
    s_fin
  } state_t;

  state_t          state;
  logic [n-1:0]    mcand;
  logic [n-1:0]    hi;
  logic [n-1:0]    lo;
  logic [cw-1:0]   cnt;
  logic [n-1:0]    addend;
  logic [n-1:0]    sum;
  logic            co;
  logic [2*n-1:0]  next_p;

  assign addend = lo[0] ? mcand : '0;

  rca_nb #(.n(n)) u_add (
    .a   (hi),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .co  (co)
  );

  // Carry lands in the top bit so the running product never overflows.
  assign next_p = {co, sum, lo[n-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_idle;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= s_run;
          end
        end
        s_run: begin
          {hi, lo} <= next_p;
          cnt      <= cnt + cw'(1);
          if (cnt == last) begin
            prod  <= next_p;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= s_fin;
          end
        end
        s_fin: begin
          done  <= 1'b0;
          state <= s_idle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= s_idle;
        end
      endcase
    end
  end

endmodule
